// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV64I decode-and-issue stage feeding the ALU through a one-entry ID/EX register
// Decodes the ALU, load/store and beq subset into operands, select and control bits.
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [3:0]      o_alu_sel,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_branch,
    output logic            o_illegal
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [3:0]      w_sel;
    logic [4:0]      w_rd;
    logic            w_reg_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_branch;
    logic            w_illegal;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [3:0]      r_sel;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_branch;
    logic            r_illegal;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};

    // Unrecognised encodings fall through to the all-zero illegal record.
    always_comb begin
        w_op1       = '0;
        w_op2       = '0;
        w_sel       = SEL_AND;
        w_rd        = 5'd0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b1;
        case (w_opcode)
            OPC_R: begin
                if (w_f7 == 7'b0000000 && (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110)) begin
                    w_illegal = 1'b0;
                    w_sel     = (w_f3 == 3'b000) ? SEL_ADD : (w_f3 == 3'b111) ? SEL_AND : SEL_OR;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_illegal = 1'b0;
                    w_sel     = SEL_SUB;
                end
                if (!w_illegal) begin
                    w_op1       = i_rs1_data;
                    w_op2       = i_rs2_data;
                    w_rd        = i_instr[11:7];
                    w_reg_write = 1'b1;
                end
            end
            OPC_I: begin
                if (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110) begin
                    w_illegal   = 1'b0;
                    w_sel       = (w_f3 == 3'b000) ? SEL_ADD : (w_f3 == 3'b111) ? SEL_AND : SEL_OR;
                    w_op1       = i_rs1_data;
                    w_op2       = w_imm_i;
                    w_rd        = i_instr[11:7];
                    w_reg_write = 1'b1;
                end
            end
            OPC_LD: begin
                if (w_f3 == 3'b011) begin
                    w_illegal   = 1'b0;
                    w_sel       = SEL_ADD;
                    w_op1       = i_rs1_data;
                    w_op2       = w_imm_i;
                    w_rd        = i_instr[11:7];
                    w_reg_write = 1'b1;
                    w_mem_read  = 1'b1;
                end
            end
            OPC_SD: begin
                if (w_f3 == 3'b011) begin
                    w_illegal   = 1'b0;
                    w_sel       = SEL_ADD;
                    w_op1       = i_rs1_data;
                    w_op2       = w_imm_s;
                    w_mem_write = 1'b1;
                end
            end
            OPC_BR: begin
                if (w_f3 == 3'b000) begin
                    w_illegal = 1'b0;
                    w_sel     = SEL_SUB;
                    w_op1     = i_rs1_data;
                    w_op2     = i_rs2_data;
                    w_branch  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_in_ready = !r_valid || i_out_ready;
    // Flush blocks capture even though in_ready may read 1.
    assign w_accept   = i_in_valid && o_in_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sel       <= SEL_AND;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_sel       <= w_sel;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_branch    <= w_branch;
            r_illegal   <= w_illegal;
        end else if (i_flush || i_out_ready) begin
            r_valid     <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_op1       = r_op1;
    assign o_op2       = r_op2;
    assign o_alu_sel   = r_sel;
    assign o_rd        = r_rd;
    assign o_reg_write = r_reg_write;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_branch    = r_branch;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - table-driven self-checking bench for alu_issue
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  alu_sel;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic [4:0]  ctrl;   // {reg_write, mem_read, mem_write, branch, illegal}
    } vec_t;

    vec_t vec[13];

    alu_issue #(.XLEN(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_instr     (instr),
        .i_rs1_data  (rs1_data),
        .i_rs2_data  (rs2_data),
        .i_flush     (flush),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_op1       (op1),
        .o_op2       (op2),
        .o_alu_sel   (alu_sel),
        .o_rd        (rd),
        .o_reg_write (reg_write),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_branch    (branch),
        .o_illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic offer(input int i);
        instr    = vec[i].instr;
        rs1_data = vec[i].rs1;
        rs2_data = vec[i].rs2;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0]  = '{32'h002081B3, 64'd5,  64'd7,  64'd5,  64'd7,  4'b0010, 5'd3, 5'b10000};
        vec[1]  = '{32'h402081B3, 64'd10, 64'd3,  64'd10, 64'd3,  4'b0110, 5'd3, 5'b10000};
        vec[2]  = '{32'hFFF00093, 64'd0,  64'd9,  64'd0,  64'hFFFFFFFFFFFFFFFF, 4'b0010, 5'd1, 5'b10000};
        vec[3]  = '{32'h007372B3, 64'hF0, 64'h3C, 64'hF0, 64'h3C, 4'b0000, 5'd5, 5'b10000};
        vec[4]  = '{32'h007362B3, 64'hA5, 64'h5A, 64'hA5, 64'h5A, 4'b0001, 5'd5, 5'b10000};
        vec[5]  = '{32'h7FF17213, 64'h1234, 64'd1, 64'h1234, 64'h7FF, 4'b0000, 5'd4, 5'b10000};
        vec[6]  = '{32'h80016213, 64'h77, 64'd1, 64'h77, 64'hFFFFFFFFFFFFF800, 4'b0001, 5'd4, 5'b10000};
        vec[7]  = '{32'h0104B403, 64'h1000, 64'd2, 64'h1000, 64'd16, 4'b0010, 5'd8, 5'b11000};
        vec[8]  = '{32'hFE20BC23, 64'h2000, 64'd3, 64'h2000, 64'hFFFFFFFFFFFFFFF8, 4'b0010, 5'd0, 5'b00100};
        vec[9]  = '{32'h00208463, 64'd4,  64'd4,  64'd4,  64'd4,  4'b0110, 5'd0, 5'b00010};
        vec[10] = '{32'h0000007F, 64'd11, 64'd12, 64'd0,  64'd0,  4'b0000, 5'd0, 5'b00001};
        vec[11] = '{32'h022081B3, 64'd13, 64'd14, 64'd0,  64'd0,  4'b0000, 5'd0, 5'b00001};
        vec[12] = '{32'h0104A403, 64'd15, 64'd16, 64'd0,  64'd0,  4'b0000, 5'd0, 5'b00001};

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_alu_sel",   {60'd0, alu_sel},   64'd0);
        chk("rst_op1",       op1,                64'd0);
        chk("rst_ctrl", {59'd0, reg_write, mem_read, mem_write, branch, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back issue with out_ready held high: one entry per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            offer(i);
            step();
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},  64'd1);
            chk($sformatf("v%0d_op1", i), op1, vec[i].op1);
            chk($sformatf("v%0d_op2", i), op2, vec[i].op2);
            chk($sformatf("v%0d_sel", i), {60'd0, alu_sel}, {60'd0, vec[i].sel});
            chk($sformatf("v%0d_rd", i),  {59'd0, rd}, {59'd0, vec[i].rd});
            chk($sformatf("v%0d_ctrl", i),
                {59'd0, reg_write, mem_read, mem_write, branch, illegal}, {59'd0, vec[i].ctrl});
        end

        // Consume without new accept: valid drops, payload holds.
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_illegal_hold", {63'd0, illegal}, 64'd1);

        // Stall for 3 cycles with a pending offer.
        offer(0);
        out_ready = 1'b0;
        step();
        chk("stall_load_valid", {63'd0, out_valid}, 64'd1);
        offer(1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
            chk($sformatf("stall%0d_op1", c), op1, 64'd5);
            chk($sformatf("stall%0d_sel", c), {60'd0, alu_sel}, 64'h2);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("release_valid", {63'd0, out_valid}, 64'd1);
        chk("release_op1", op1, 64'd10);
        chk("release_sel", {60'd0, alu_sel}, 64'h6);

        // Flush together with a valid, ready offer.
        offer(6);
        flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_sel_not_captured", {60'd0, alu_sel}, 64'h6);
        chk("flush_op2_not_captured", op2, 64'd3);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_flush_valid", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while an entry is stalled.
        offer(0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_op1", op1, 64'd0);
        chk("async_rst_rw", {63'd0, reg_write}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that drives the 64-bit ALU's operand and select inputs. It accepts one RV64I instruction per handshake with its register-file operands, decodes it into `op1`, `op2` and a 4-bit `alu_sel` (AND 0000, OR 0001, ADD 0010, SUB 0110), and holds the result in a one-entry ID/EX register with a valid/ready handshake. It also produces the writeback, memory and branch control bits that accompany each issued operation.

## Interface
- `XLEN`, 64, operand/result width; must match the ALU.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `rs1_data`  in  XLEN  register-file read port 1.
- `rs2_data`  in  XLEN  register-file read port 2.
- `flush`  in  1  kill the held entry; drop any entry offered this cycle.
- `out_valid`  out  1  the ID/EX entry is valid.
- `out_ready`  in  1  downstream (ALU/EX) consumes the entry this cycle.
- `op1`, `op2`  out  XLEN  ALU operands.
- `alu_sel`  out  4  ALU operation select.
- `rd`  out  5  destination register.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `illegal`  out  1 each  control bits.

## Operation
- Accept when `in_valid && in_ready && !flush`; `in_ready = !out_valid || out_ready` (combinational, no dependence on `in_valid`).
- Decode by opcode `instr[6:0]`, funct3 `instr[14:12]`, funct7 `instr[31:25]`:
  - `0110011` R-type, op1=rs1, op2=rs2, reg_write=1: f7=0000000/f3=000 ADD; f7=0100000/f3=000 SUB; f7=0000000/f3=111 AND; f7=0000000/f3=110 OR.
  - `0010011` I-type, op2=sext(instr[31:20]), reg_write=1: f3=000 ADD, 111 AND, 110 OR.
  - `0000011` ld (f3=011): ADD, op2=sext(instr[31:20]), mem_read=1, reg_write=1.
  - `0100011` sd (f3=011): ADD, op2=sext({instr[31:25],instr[11:7]}), mem_write=1, rd=0.
  - `1100011` beq (f3=000): SUB, op2=rs2, branch=1, rd=0.
- All sign extension goes from the immediate MSB `instr[31]` to XLEN bits.
- Any other encoding: captured with `illegal=1`, `alu_sel=0000`, op1=op2=0, rd=0, all other control bits 0.
- Register load: on accept, all outputs load together. When `out_valid && out_ready` with no new accept, `out_valid` clears and the payload holds its last value.

## Timing
- Reset (asynchronous, `rst_n`=0): `out_valid`=0, op1=op2=0, `alu_sel`=0000, rd=0, all control bits 0. `in_ready`=1 while in reset.
- Latency: 1 cycle. An instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: 1 per cycle when `out_ready` is held high.
  - A consume and a new accept in the same cycle replace the entry; `out_valid` stays 1.
- Stall: `out_valid && !out_ready` forces `in_ready`=0. Outputs stay stable until consumed or flushed.
- Flush: `out_valid` goes 0 at the next edge regardless of `in_valid`/`out_ready`.
  - An instruction offered in the same cycle is not captured, even though `in_ready` may read 1.
- Reset asserted mid-stall: the entry is lost immediately; no partial update.

## Test plan
- Reset -> `out_valid`=0, `alu_sel`=0000, `in_ready`=1; release, then `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7 -> next cycle op1=5, op2=7, alu_sel=0010, rd=3, reg_write=1.
- `sub` (0x402081B3), then `addi x1,x0,-1` (0xFFF00093), back-to-back with `out_ready`=1 -> alu_sel 0110, then 0010 with op2=0xFFFFFFFFFFFFFFFF; one entry per cycle, no bubbles.
- `sd x2,-8(x1)` (0xFE20BC23) -> op2=0xFFFFFFFFFFFFFFF8, mem_write=1, rd=0, reg_write=0; `beq` -> alu_sel=0110, branch=1.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and outputs stable for all 3; on release the held entry is consumed and the pending instruction is accepted that same cycle.
- `flush`=1 together with a valid, ready offer -> `out_valid`=0 next cycle and the offered instruction never appears.
- Opcode 0x7F, and `add` with f7=0000001 -> illegal=1, alu_sel=0000, reg_write=0; asynchronous reset while an entry is stalled -> `out_valid` drops without waiting for a clock edge.
